ime_sad_search: RTL
===================

Name: ime_sad_search

Overview:
- Integer motion estimation (IME) stage, directly upstream of the fractional ME stage.
- Performs a full exhaustive SAD search of a 4x4 current block over a 16x16 reference window held in internal storage.
- Outputs the best integer position as an 8-bit raster index (y*16+x), the same pix_pos format the FME stage consumes, plus the winning SAD.
- Sequential engine: one block row per cycle, one compare cycle per candidate.

Parameters:
- SMIN, 1: minimum candidate x and y (top-left of the 4x4 block).
- SMAX, 11: maximum candidate x and y. Constraint: SMIN <= SMAX and SMAX+3 <= 15.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-low reset
- ref_we  in  1  reference window write enable
- ref_addr  in  8  reference write address (y*16+x)
- ref_data  in  8  reference pixel
- cur_we  in  1  current block write enable
- cur_addr  in  4  current pixel address (row*4+col)
- cur_data  in  8  current pixel
- start  in  1  begin search; sampled only in IDLE
- busy  out  1  high while a search is in progress
- done  out  1  one-cycle pulse when results are valid
- best_pos  out  8  winning position, y*16+x
- best_sad  out  12  winning SAD (maximum 16*255 = 4080)

Behaviour:
- Reset (async, rst low):
  - FSM goes to IDLE; busy, done, best_pos and best_sad go to 0.
  - Candidate counters and accumulator clear.
  - Pixel storage is not cleared and retains its contents.
  - Reset mid-search aborts the search immediately; no done pulse is produced.
- Storage:
  - 256x8 reference array and 16x8 current array, with synchronous write and combinational read.
  - ref_we and cur_we take effect only in IDLE; in any other state they are ignored.
  - A write and start in the same IDLE cycle: the write lands first and the search uses the new data.
- FSM states are IDLE, ACC, CMP, DONE.
  - IDLE: on start=1, set cx=cy=SMIN, acc=0, run_best=4095, run_pos=0, busy=1, and go to ACC with row r=0.
  - ACC (4 cycles, r=0..3): acc += sum over c=0..3 of |cur[r*4+c] - ref[(cy+r)*16+cx+c]|.
    - Differences are unsigned 8-bit absolute values; the accumulator is 12 bits and cannot overflow.
    - After r=3, go to CMP.
  - CMP (1 cycle):
    - If acc < run_best (strict), update run_best=acc and run_pos=cy*16+cx. Ties keep the earlier candidate.
    - Advance in raster order: cx increments; when cx reaches SMAX, cx wraps to SMIN and cy increments.
    - If the candidate was (SMAX,SMAX), go to DONE; otherwise clear acc, set r=0 and go to ACC.
  - DONE (1 cycle): best_pos=run_pos, best_sad=run_sad, done=1, busy=0, then go to IDLE.
- Timing:
  - N = (SMAX-SMIN+1)^2 candidates, 5 cycles each.
  - done is high during cycle 5N+1 after the edge that samples start; default N=121 gives cycle 606.
- Outputs: best_pos and best_sad hold their values until the next DONE. done is low in all other cycles.
- start is ignored while busy (ACC, CMP or DONE); there is no queueing.
- The first candidate is always accepted, since run_best starts at 4095, which exceeds any achievable SAD.

Test Plan:
1. Ref all 0x10; cur = 0x80..0x8F; the cur pattern is also written at x=5, y=7; start -> done at cycle 606, best_pos=0x75, best_sad=0.
2. Ref all 0x00, cur all 0xFF (all candidates tie at 4080) -> best_pos=0x11, best_sad=0xFF0 (first raster candidate wins).
3. Exact matches at (3,2) and (9,9), background differing -> best_pos=0x23, best_sad=0; the strict-less compare is verified.
4. Only candidate (11,11) within SAD 3, all others >= 20 -> best_pos=0xBB, best_sad=3; covers the window-corner boundary.
5. Start pulsed again at cycles 100 and 605, plus ref_we at cycle 200 writing into the matching block -> both ignored; exactly one done at 606 with the unmodified result.
6. rst low at cycle 300 mid-search -> busy=0, done=0, best_pos=0, best_sad=0 immediately. After release, a new start with no reloads gives the same result as scenario 1 (storage retained).

Source files
------------

// File: rtl/ime_sad_search.sv
// rtl/ime_sad_search.sv - exhaustive 4x4 integer SAD search over a 16x16 reference window
module ime_sad_search #(
  parameter int SMIN = 1,
  parameter int SMAX = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ref_we,
  input  logic [7:0]  ref_addr,
  input  logic [7:0]  ref_data,
  input  logic        cur_we,
  input  logic [3:0]  cur_addr,
  input  logic [7:0]  cur_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  best_pos,
  output logic [11:0] best_sad
);

  typedef enum logic [1:0] {IDLE, ACC, CMP, DONE} state_t;

  localparam logic [3:0] SMIN_C = 4'(SMIN);
  localparam logic [3:0] SMAX_C = 4'(SMAX);

  state_t      state, state_nxt;
  logic [7:0]  ref_mem [256];
  logic [7:0]  cur_mem [16];
  logic [3:0]  cx, cy;
  logic [1:0]  r;
  logic [11:0] acc, run_best;
  logic [7:0]  run_pos;
  logic [9:0]  row_sad;
  logic [7:0]  cp, rp;
  logic        better, last_cand;

  always_ff @(posedge clk) begin
    if (state == IDLE && ref_we) ref_mem[ref_addr] <= ref_data;
    if (state == IDLE && cur_we) cur_mem[cur_addr] <= cur_data;
  end

  always_comb begin
    row_sad = '0;
    cp      = '0;
    rp      = '0;
    for (int c = 0; c < 4; c++) begin
      cp      = cur_mem[{r, 2'(c)}];
      rp      = ref_mem[{cy + {2'b00, r}, 4'b0000} + {4'b0000, cx} + 8'(c)];
      row_sad = row_sad + 10'(cp > rp ? cp - rp : rp - cp);
    end
  end

  assign better    = acc < run_best;
  assign last_cand = (cx == SMAX_C) && (cy == SMAX_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = ACC;
      ACC: begin
        busy = 1'b1;
        if (r == 2'd3) state_nxt = CMP;
      end
      CMP: begin
        busy      = 1'b1;
        state_nxt = last_cand ? DONE : ACC;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx       <= '0;
      cy       <= '0;
      r        <= '0;
      acc      <= '0;
      run_best <= '0;
      run_pos  <= '0;
      best_pos <= '0;
      best_sad <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cx       <= SMIN_C;
          cy       <= SMIN_C;
          r        <= '0;
          acc      <= '0;
          run_best <= 12'hFFF;
          run_pos  <= '0;
        end
        ACC: begin
          acc <= acc + 12'(row_sad);
          r   <= r + 2'd1;
        end
        CMP: begin
          if (better) begin
            run_best <= acc;
            run_pos  <= {cy, cx};
          end
          // Results are loaded on the edge into DONE so they are already valid while done is high
          if (last_cand) begin
            best_sad <= better ? acc : run_best;
            best_pos <= better ? {cy, cx} : run_pos;
          end else begin
            acc <= '0;
            r   <= '0;
            if (cx == SMAX_C) begin
              cx <= SMIN_C;
              cy <= cy + 4'd1;
            end else begin
              cx <= cx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
